// File: rtl/uart_cmd_ctrl.sv
// UART command controller: frames opcode+args, drives an LED bank, answers ACK/NAK.
// Optional trailing XOR checksum byte and CHECK state: define UART_CMD_CHECKSUM_EN.
module uart_cmd_ctrl #(
   parameter int         LED_W       = 3,
   parameter int         ARG_BYTES   = 1,
   parameter int         TIMEOUT_CYC = 1000,
   parameter logic [7:0] ACK_BYTE    = 8'h06,
   parameter logic [7:0] NAK_BYTE    = 8'h15
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   input  logic             rx_err,
   output logic             rx_en,
   output logic             tx_valid,
   output logic [7:0]       tx_data,
   input  logic             tx_ready,
   output logic [LED_W-1:0] led,
   output logic             busy
);

`ifdef UART_CMD_CHECKSUM_EN
   localparam int NBYTES = ARG_BYTES + 1;
   localparam logic [2:0] ARG_CNT = 3'(ARG_BYTES);
`else
   localparam int NBYTES = ARG_BYTES;
`endif
   localparam logic [2:0] LAST = 3'(NBYTES - 1);
   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARGS,
      S_CHECK,
      S_EXEC,
      S_RESP,
      S_RESP2
   } state_t;

   state_t           r_state;
   logic [7:0]       r_op;
   logic [LED_W-1:0] r_arg;
   logic [2:0]       r_cnt;
   logic [TW-1:0]    r_timer;
   logic [LED_W-1:0] r_led;
   logic             r_tx_valid;
   logic [7:0]       r_tx_data;
   logic             r_rx_en;
   logic             r_busy;
   logic             r_resp2;
`ifdef UART_CMD_CHECKSUM_EN
   logic [7:0]       r_xor;
   logic [7:0]       r_csum;
`endif

   // Only the low LED_W bits of the packed argument are ever consumed,
   // and those always come from the last argument byte.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_op       <= '0;
         r_arg      <= '0;
         r_cnt      <= '0;
         r_timer    <= '0;
         r_led      <= '0;
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
         r_rx_en    <= 1'b1;
         r_busy     <= 1'b0;
         r_resp2    <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
         r_xor      <= '0;
         r_csum     <= '0;
`endif
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (rx_err) begin
                  r_tx_data  <= NAK_BYTE;
                  r_tx_valid <= 1'b1;
                  r_resp2    <= 1'b0;
                  r_rx_en    <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_RESP;
               end else if (rx_valid) begin
                  r_op    <= rx_data;
                  r_cnt   <= '0;
                  r_timer <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_ARGS;
`ifdef UART_CMD_CHECKSUM_EN
                  r_xor   <= rx_data;
`endif
               end
            end
            S_ARGS: begin
               if (rx_err) begin
                  r_tx_data  <= NAK_BYTE;
                  r_tx_valid <= 1'b1;
                  r_resp2    <= 1'b0;
                  r_rx_en    <= 1'b0;
                  r_state    <= S_RESP;
               end else if (rx_valid) begin
                  r_timer <= '0;
                  r_cnt   <= r_cnt + 3'd1;
`ifdef UART_CMD_CHECKSUM_EN
                  if (r_cnt < ARG_CNT) begin
                     r_arg <= rx_data[LED_W-1:0];
                     r_xor <= r_xor ^ rx_data;
                  end else begin
                     r_csum <= rx_data;
                  end
`else
                  r_arg <= rx_data[LED_W-1:0];
`endif
                  if (r_cnt == LAST) begin
                     r_rx_en <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
                     r_state <= S_CHECK;
`else
                     r_state <= S_EXEC;
`endif
                  end
               end else if (r_timer == TMAX) begin
                  r_tx_data  <= NAK_BYTE;
                  r_tx_valid <= 1'b1;
                  r_resp2    <= 1'b0;
                  r_rx_en    <= 1'b0;
                  r_state    <= S_RESP;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
`ifdef UART_CMD_CHECKSUM_EN
            S_CHECK: begin
               if (r_csum == r_xor) begin
                  r_state <= S_EXEC;
               end else begin
                  r_tx_data  <= NAK_BYTE;
                  r_tx_valid <= 1'b1;
                  r_resp2    <= 1'b0;
                  r_state    <= S_RESP;
               end
            end
`endif
            S_EXEC: begin
               r_state    <= S_RESP;
               r_tx_valid <= 1'b1;
               r_tx_data  <= ACK_BYTE;
               r_resp2    <= 1'b0;
               case (r_op)
                  8'h01: r_led <= r_arg;
                  8'h02: r_led <= '0;
                  8'h03: r_led <= LED_W'(1);
                  8'h04: r_led <= r_led ^ r_arg;
                  8'h05: r_resp2 <= 1'b1;
                  default: r_tx_data <= NAK_BYTE;
               endcase
            end
            S_RESP: begin
               if (tx_ready) begin
                  if (r_resp2) begin
                     r_resp2   <= 1'b0;
                     r_tx_data <= 8'(r_led);
                     r_state   <= S_RESP2;
                  end else begin
                     r_tx_valid <= 1'b0;
                     r_rx_en    <= 1'b1;
                     r_busy     <= 1'b0;
                     r_state    <= S_IDLE;
                  end
               end
            end
            S_RESP2: begin
               if (tx_ready) begin
                  r_tx_valid <= 1'b0;
                  r_rx_en    <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            default: begin
               r_tx_valid <= 1'b0;
               r_rx_en    <= 1'b1;
               r_busy     <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign rx_en    = r_rx_en;
   assign tx_valid = r_tx_valid;
   assign tx_data  = r_tx_data;
   assign led      = r_led;
   assign busy     = r_busy;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: expected tx bytes queued by stimulus,
// popped by a monitor on each tx handshake; LED and timing checked inline.
module tb_uart_cmd_ctrl;
   localparam int LED_W = 3;
   localparam int TO    = 1000;
`ifdef UART_CMD_CHECKSUM_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             rx_valid = 1'b0;
   logic [7:0]       rx_data = 8'h00;
   logic             rx_err = 1'b0;
   logic             rx_en;
   logic             tx_valid;
   logic [7:0]       tx_data;
   logic             tx_ready = 1'b1;
   logic [LED_W-1:0] led;
   logic             busy;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_e;

   uart_cmd_ctrl #(
      .LED_W(LED_W),
      .ARG_BYTES(1),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .rx_valid(rx_valid),
      .rx_data(rx_data),
      .rx_err(rx_err),
      .rx_en(rx_en),
      .tx_valid(tx_valid),
      .tx_data(tx_data),
      .tx_ready(tx_ready),
      .led(led),
      .busy(busy)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   always @(negedge clock) begin
      if (!reset && tx_valid && tx_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL tx_unexpected got %02h want none", tx_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (tx_data !== mon_e) begin
               n_err++;
               $display("FAIL tx_byte got %02h want %02h", tx_data, mon_e);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      cyc();
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [7:0] arg);
      send_byte(op);
      send_byte(arg);
`ifdef UART_CMD_CHECKSUM_EN
      send_byte(op ^ arg);
`endif
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (exp_q.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
         cyc();
      end
      chk("idle_wait", 32'(ok), 32'd1);
   endtask

   initial begin
      repeat (3) cyc();
      reset = 1'b0;
      cyc();
      chk("rst_led", 32'(led), 0);
      chk("rst_txv", 32'(tx_valid), 0);
      chk("rst_txd", 32'(tx_data), 0);
      chk("rst_rxen", 32'(rx_en), 1);
      chk("rst_busy", 32'(busy), 0);

      // LED0 with exact latency
      exp_q.push_back(8'h06);
      send_frame(8'h03, 8'h00);
      repeat (EXTRA) cyc();
      chk("lat_txv_pre", 32'(tx_valid), 0);
      chk("lat_led_pre", 32'(led), 0);
      chk("lat_rxen_ex", 32'(rx_en), 0);
      chk("lat_busy_ex", 32'(busy), 1);
      cyc();
      chk("lat_led", 32'(led), 1);
      chk("lat_txv", 32'(tx_valid), 1);
      chk("lat_txd", 32'(tx_data), 32'h06);
      cyc();
      chk("lat_txv_drop", 32'(tx_valid), 0);
      chk("lat_rxen_back", 32'(rx_en), 1);
      chk("lat_busy_back", 32'(busy), 0);

      // reset in the middle of ARGS
      send_byte(8'h01);
      cyc();
      chk("mid_busy", 32'(busy), 1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_led", 32'(led), 0);
      chk("mid_rst_txv", 32'(tx_valid), 0);
      chk("mid_rst_rxen", 32'(rx_en), 1);
      chk("mid_rst_busy", 32'(busy), 0);
      @(posedge clock);
      #1 reset = 1'b0;
      cyc();

      exp_q.push_back(8'h06);
      send_frame(8'h01, 8'h05);
      wait_idle();
      chk("set_led", 32'(led), 32'h5);

      exp_q.push_back(8'h06);
      send_frame(8'h04, 8'h07);
      wait_idle();
      chk("tog_led", 32'(led), 32'h2);

      // READ with a stalled transmitter
      tx_ready = 1'b0;
      exp_q.push_back(8'h06);
      exp_q.push_back(8'h02);
      send_frame(8'h05, 8'h00);
      repeat (1 + EXTRA) cyc();
      for (int i = 0; i < 5; i++) begin
         chk("stall_txv", 32'(tx_valid), 1);
         chk("stall_txd", 32'(tx_data), 32'h06);
         cyc();
      end
      tx_ready = 1'b1;
      cyc();
      chk("rd2_txv", 32'(tx_valid), 1);
      chk("rd2_txd", 32'(tx_data), 32'h02);
      wait_idle();
      chk("rd_led", 32'(led), 32'h2);

      exp_q.push_back(8'h15);
      send_frame(8'h7F, 8'h00);
      wait_idle();
      chk("bad_op_led", 32'(led), 32'h2);

      // framing error between opcode and argument
      exp_q.push_back(8'h15);
      send_byte(8'h01);
      cyc();
      rx_err = 1'b1;
      cyc();
      rx_err = 1'b0;
      wait_idle();
      chk("err_led", 32'(led), 32'h2);

      // error and byte in the same cycle: byte discarded
      exp_q.push_back(8'h15);
      send_byte(8'h02);
      rx_err   = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h00;
      cyc();
      rx_err   = 1'b0;
      rx_valid = 1'b0;
      wait_idle();
      chk("errv_led", 32'(led), 32'h2);

      // inter-byte timeout
      exp_q.push_back(8'h15);
      send_byte(8'h01);
      repeat (TO - 1) cyc();
      chk("to_txv_pre", 32'(tx_valid), 0);
      chk("to_busy_pre", 32'(busy), 1);
      cyc();
      chk("to_txv", 32'(tx_valid), 1);
      chk("to_txd", 32'(tx_data), 32'h15);
      wait_idle();
      chk("to_led", 32'(led), 32'h2);

      // only the low LED_W argument bits reach the LEDs
      exp_q.push_back(8'h06);
      send_frame(8'h01, 8'hFD);
      wait_idle();
      chk("mask_led", 32'(led), 32'h5);

      exp_q.push_back(8'h06);
      send_frame(8'h02, 8'h00);
      wait_idle();
      chk("clr_led", 32'(led), 0);

`ifdef UART_CMD_CHECKSUM_EN
      exp_q.push_back(8'h06);
      send_byte(8'h01);
      send_byte(8'h06);
      send_byte(8'h07);
      cyc();
      chk("cs_txv_pre", 32'(tx_valid), 0);
      chk("cs_led_pre", 32'(led), 0);
      cyc();
      chk("cs_led", 32'(led), 32'h6);
      chk("cs_txv", 32'(tx_valid), 1);
      wait_idle();

      exp_q.push_back(8'h15);
      send_byte(8'h01);
      send_byte(8'h06);
      send_byte(8'h00);
      wait_idle();
      chk("cs_bad_led", 32'(led), 32'h6);
`endif

      repeat (5) cyc();
      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
